// File: rtl/arena_grid.sv
// arena_grid: shared 80x60 light-cycle tile map, move/collision port and VGA read port.
// Define ARENA_HIT_COUNT_EN to add per-player saturating hit counters.
module arena_grid #(
  parameter int COLS       = 80,
  parameter int ROWS       = 60,
  parameter int BORDER     = 2,
  parameter int TILE_SHIFT = 3,
  parameter int ADDR_W     = 13
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        clear,
  output logic        busy,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [13:0] req_cur_col,
  input  logic [11:0] req_cur_row,
  input  logic [13:0] req_nxt_col,
  input  logic [11:0] req_nxt_row,
  output logic [1:0]  resp_valid,
  output logic [1:0]  resp_hit,
  input  logic [9:0]  pix_x,
  input  logic [9:0]  pix_y,
  output logic [1:0]  tile_out
`ifdef ARENA_HIT_COUNT_EN
  ,
  output logic [7:0]  hit_count1,
  output logic [7:0]  hit_count2
`endif
);

  localparam int DEPTH = COLS * ROWS;
  localparam logic [6:0] C_END = 7'(COLS);
  localparam logic [6:0] C_LO  = 7'(BORDER);
  localparam logic [6:0] C_HI  = 7'(COLS - BORDER);
  localparam logic [5:0] R_END = 6'(ROWS);
  localparam logic [5:0] R_LO  = 6'(BORDER);
  localparam logic [5:0] R_HI  = 6'(ROWS - BORDER);
  localparam logic [9:0] PC_END = 10'(COLS);
  localparam logic [9:0] PR_END = 10'(ROWS);
  localparam logic [ADDR_W-1:0] A_LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {CLEAR, IDLE, WRITE, CHECK} state_t;

  function automatic logic [ADDR_W-1:0] tile_addr(
    input logic [6:0] c,
    input logic [5:0] r
  );
    return ADDR_W'(r) * ADDR_W'(COLS) + ADDR_W'(c);
  endfunction

  state_t state, state_n;
  logic [1:0] mem [DEPTH];

  logic [ADDR_W-1:0] clr_addr;
  logic [6:0] clr_col;
  logic [5:0] clr_row;
  logic rr, id;
  logic [6:0] cur_c, nxt_c;
  logic [5:0] cur_r, nxt_r;
  logic [1:0] rd_q;
  logic oob_q;

  logic [1:0] grant, code;
  logic cur_oob, nxt_oob, wall, pix_oob;
  logic [ADDR_W-1:0] cur_a, nxt_a, pix_a;
  logic [9:0] pc, pr;

  assign code    = id ? 2'd3 : 2'd1;
  assign cur_oob = (cur_c >= C_END) || (cur_r >= R_END);
  assign nxt_oob = (nxt_c >= C_END) || (nxt_r >= R_END);
  assign cur_a   = tile_addr(cur_c, cur_r);
  assign nxt_a   = tile_addr(nxt_c, nxt_r);
  assign wall    = (clr_row < R_LO) || (clr_row >= R_HI) ||
                   (clr_col < C_LO) || (clr_col >= C_HI);

  assign pc      = pix_x >> TILE_SHIFT;
  assign pr      = pix_y >> TILE_SHIFT;
  assign pix_oob = (pc >= PC_END) || (pr >= PR_END);
  assign pix_a   = tile_addr(pc[6:0], pr[5:0]);

  always_comb begin
    req_ready = 2'b00;
    if (state == IDLE && !clear) begin
      unique case (1'b1)
        req_valid == 2'b11: req_ready = rr ? 2'b10 : 2'b01;
        req_valid == 2'b00: req_ready = 2'b11;
        default:            req_ready = req_valid;
      endcase
    end
  end

  assign grant = req_ready & req_valid;

  always_comb begin
    state_n = state;
    unique case (state)
      CLEAR: if (clr_addr == A_LAST) state_n = IDLE;
      IDLE:  if (|grant) state_n = WRITE;
      WRITE: state_n = CHECK;
      CHECK: state_n = IDLE;
      default: state_n = CLEAR;
    endcase
    if (clear) state_n = CLEAR;
  end

  always_comb begin
    resp_valid = 2'b00;
    if (state == CHECK && !clear) resp_valid = id ? 2'b10 : 2'b01;
  end

  assign resp_hit = resp_valid & {2{oob_q || (rd_q != 2'd0)}};

  always_ff @(posedge CLOCK_50) begin
    if (state == CLEAR && !clear)
      mem[clr_addr] <= wall ? 2'd2 : 2'd0;
    else if (state == WRITE && !clear && !cur_oob)
      mem[cur_a] <= code;
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state    <= CLEAR;
      busy     <= 1'b0;
      tile_out <= 2'd0;
      clr_addr <= '0;
      clr_col  <= '0;
      clr_row  <= '0;
      rr       <= 1'b0;
      id       <= 1'b0;
      cur_c    <= '0;
      cur_r    <= '0;
      nxt_c    <= '0;
      nxt_r    <= '0;
      rd_q     <= 2'd0;
      oob_q    <= 1'b0;
    end else begin
      state    <= state_n;
      busy     <= clear || (state == CLEAR);
      tile_out <= (busy || state == CLEAR || pix_oob) ? 2'd0 : mem[pix_a];
      if (clear) begin
        clr_addr <= '0;
        clr_col  <= '0;
        clr_row  <= '0;
      end else if (state == CLEAR) begin
        clr_addr <= clr_addr + 1'b1;
        if (clr_col == C_END - 7'd1) begin
          clr_col <= '0;
          clr_row <= clr_row + 1'b1;
        end else begin
          clr_col <= clr_col + 1'b1;
        end
      end
      if (state == IDLE && |grant) begin
        id    <= grant[1];
        cur_c <= grant[1] ? req_cur_col[13:7] : req_cur_col[6:0];
        cur_r <= grant[1] ? req_cur_row[11:6] : req_cur_row[5:0];
        nxt_c <= grant[1] ? req_nxt_col[13:7] : req_nxt_col[6:0];
        nxt_r <= grant[1] ? req_nxt_row[11:6] : req_nxt_row[5:0];
        if (&req_valid) rr <= ~rr;
      end
      // a move onto its own tile must see the trail written this cycle
      if (state == WRITE) begin
        oob_q <= nxt_oob;
        if (nxt_oob)
          rd_q <= 2'd0;
        else if (nxt_c == cur_c && nxt_r == cur_r)
          rd_q <= code;
        else
          rd_q <= mem[nxt_a];
      end
    end
  end

`ifdef ARENA_HIT_COUNT_EN
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      hit_count1 <= 8'd0;
      hit_count2 <= 8'd0;
    end else if (clear) begin
      hit_count1 <= 8'd0;
      hit_count2 <= 8'd0;
    end else begin
      if (resp_hit[0] && hit_count1 != 8'hFF) hit_count1 <= hit_count1 + 8'd1;
      if (resp_hit[1] && hit_count2 != 8'hFF) hit_count2 <= hit_count2 + 8'd1;
    end
  end
`endif

endmodule
